// File: rtl/cgra_pkg.sv
// -----------------------------------------------------------------------------
// cgra_pkg
//   Shared CGRA parameters plus the column memory-port additions used by
//   cgra_col_mem_resp and cgra_rr_arbiter.
//   N_COL / DP_WIDTH    : column count and datapath width.
//   MEM_*               : scratchpad geometry (banks are word-interleaved).
//   mem_req_t           : one column's request payload.
// -----------------------------------------------------------------------------
package cgra_pkg;

    localparam int N_COL    = 4;
    localparam int DP_WIDTH = 32;
    localparam int COL_W    = (N_COL > 1) ? $clog2(N_COL) : 1;

    localparam int MEM_N_BANKS    = 4;
    localparam int MEM_BANK_DEPTH = 256;
    localparam int MEM_BANK_LOG2  = $clog2(MEM_N_BANKS);
    localparam int MEM_ROW_LOG2   = $clog2(MEM_BANK_DEPTH);

    typedef struct packed {
        logic                wen;    // 1 = read, 0 = write
        logic                ind;    // 1 = explicit address, 0 = stream pointer
        logic [DP_WIDTH-1:0] add;
        logic [DP_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/cgra_rr_arbiter.sv
// -----------------------------------------------------------------------------
// cgra_rr_arbiter
//   Round-robin arbiter for one scratchpad bank. Grant is combinational from
//   req_i; after a grant the highest priority moves to winner+1 (mod N).
//   Priority stays put when nothing is granted. Reset: column 0 first.
// Ports
//   clk_i  in  1   clock
//   rst_i  in  1   synchronous reset, active-high
//   req_i  in  N   requests targeting this bank
//   gnt_o  out N   one-hot grant (all zero when no request)
// -----------------------------------------------------------------------------
module cgra_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] prio_q;
    logic [IW-1:0] prio_d;

    always_comb begin
        int            idx;
        logic [IW-1:0] sel;
        logic          found;
        gnt_o  = '0;
        prio_d = prio_q;
        found  = 1'b0;
        idx    = 0;
        sel    = '0;
        // Scan starting at the current priority holder, wrapping at N.
        for (int k = 0; k < N; k++) begin
            idx = int'(prio_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = IW'(idx);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                prio_d     = (idx == N - 1) ? '0 : IW'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/cgra_col_mem_resp.sv
// -----------------------------------------------------------------------------
// cgra_col_mem_resp
//   Responder for the CGRA per-column data ports. A banked, word-interleaved
//   scratchpad serves all columns at once; each bank has its own round-robin
//   arbiter and a registered read port. Direct accesses (ind=0) use a
//   per-column stream pointer that post-increments by one word.
//
// Optional feature (macro CGRA_MEM_PERF_CNT_EN):
//   per-column saturating stall counters (cycles with req=1 & gnt=0),
//   ports perf_clr_i / perf_stall_o. Absent when the macro is undefined.
//
// Ports
//   clk_i          in   1                   clock
//   rst_i          in   1                   synchronous reset, active-high
//   data_req_i     in   N_COL               request, held until granted
//   data_wen_i     in   N_COL               1 = read, 0 = write
//   data_ind_i     in   N_COL               1 = data_add_i, 0 = stream pointer
//   data_add_i     in   N_COL x DP_WIDTH    byte address
//   data_wdata_i   in   N_COL x DP_WIDTH    write data
//   data_gnt_o     out  N_COL               accepted this cycle (combinational)
//   data_rvalid_o  out  N_COL               read data valid, one cycle after gnt
//   data_rdata_o   out  N_COL x DP_WIDTH    read data, held when rvalid=0
//   cfg_ptr_we_i   in   1                   load one stream pointer
//   cfg_ptr_col_i  in   COL_W               column to load
//   cfg_ptr_i      in   DP_WIDTH            pointer value
//   busy_o         out  1                   an rvalid is due next cycle
//   perf_clr_i     in   1                   (optional) clear all stall counters
//   perf_stall_o   out  N_COL x DP_WIDTH    (optional) stall counters
// -----------------------------------------------------------------------------
module cgra_col_mem_resp
    import cgra_pkg::*;
#(
    parameter int N_BANKS    = MEM_N_BANKS,
    parameter int BANK_DEPTH = MEM_BANK_DEPTH
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_COL-1:0]                data_req_i,
    input  logic [N_COL-1:0]                data_wen_i,
    input  logic [N_COL-1:0]                data_ind_i,
    input  logic [N_COL-1:0][DP_WIDTH-1:0]  data_add_i,
    input  logic [N_COL-1:0][DP_WIDTH-1:0]  data_wdata_i,
    output logic [N_COL-1:0]                data_gnt_o,
    output logic [N_COL-1:0]                data_rvalid_o,
    output logic [N_COL-1:0][DP_WIDTH-1:0]  data_rdata_o,
    input  logic                            cfg_ptr_we_i,
    input  logic [COL_W-1:0]                cfg_ptr_col_i,
    input  logic [DP_WIDTH-1:0]             cfg_ptr_i,
    output logic                            busy_o
`ifdef CGRA_MEM_PERF_CNT_EN
    ,
    input  logic                            perf_clr_i,
    output logic [N_COL-1:0][DP_WIDTH-1:0]  perf_stall_o
`endif
);

    localparam int BANK_LOG2 = $clog2(N_BANKS);
    localparam int ROW_LOG2  = $clog2(BANK_DEPTH);
    localparam int ROW_LSB   = 2 + BANK_LOG2;
    localparam int ADDR_HI   = ROW_LSB + ROW_LOG2;

    mem_req_t                    col_req   [N_COL];
    logic [DP_WIDTH-1:0]         ea        [N_COL];
    logic [BANK_LOG2-1:0]        bank_sel  [N_COL];
    logic [ROW_LOG2-1:0]         row_sel   [N_COL];
    logic [N_COL-1:0]            req_act;
    logic [N_BANKS-1:0][N_COL-1:0] bank_req;
    logic [N_BANKS-1:0][N_COL-1:0] bank_gnt;
    logic [DP_WIDTH-1:0]         bank_rdata [N_BANKS];

    logic [DP_WIDTH-1:0]         ptr_q     [N_COL];
    logic [DP_WIDTH-1:0]         ptr_d     [N_COL];
    logic [N_COL-1:0]            rvalid_q;
    logic [N_COL-1:0]            rvalid_d;
    logic [BANK_LOG2-1:0]        rbank_q   [N_COL];
    logic [DP_WIDTH-1:0]         hold_q    [N_COL];
    logic [N_COL-1:0]            unused_ea;

    // Requests are ignored while reset is asserted, so no grant can leak out.
    assign req_act = data_req_i & {N_COL{~rst_i}};

    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            col_req[c].wen   = data_wen_i[c];
            col_req[c].ind   = data_ind_i[c];
            col_req[c].add   = data_add_i[c];
            col_req[c].wdata = data_wdata_i[c];
            ea[c]       = col_req[c].ind ? col_req[c].add : ptr_q[c];
            bank_sel[c] = ea[c][2 +: BANK_LOG2];
            row_sel[c]  = ea[c][ROW_LSB +: ROW_LOG2];
        end
    end

    // Byte offset and bits above the scratchpad range do not select storage.
    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            unused_ea[c] = ^{ea[c][1:0], ea[c][DP_WIDTH-1:ADDR_HI]};
        end
    end

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            for (int c = 0; c < N_COL; c++) begin
                bank_req[b][c] = req_act[c] && (bank_sel[c] == BANK_LOG2'(b));
            end
        end
    end

    // ---------------------------------------------------------------- banks
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic                bank_en;
        logic                bank_we;
        logic [ROW_LOG2-1:0] bank_row;
        logic [DP_WIDTH-1:0] bank_wdata;
        logic [DP_WIDTH-1:0] rdata_q;
        logic [DP_WIDTH-1:0] mem_q [BANK_DEPTH];

        cgra_rr_arbiter #(
            .N (N_COL)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (bank_req[b]),
            .gnt_o (bank_gnt[b])
        );

        // Grant is one-hot, so the mux below selects exactly the winner.
        always_comb begin
            bank_en    = |bank_gnt[b];
            bank_we    = 1'b0;
            bank_row   = '0;
            bank_wdata = '0;
            for (int c = 0; c < N_COL; c++) begin
                if (bank_gnt[b][c]) begin
                    bank_we    = ~col_req[c].wen;
                    bank_row   = row_sel[c];
                    bank_wdata = col_req[c].wdata;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (bank_en) begin
                if (bank_we) begin
                    mem_q[bank_row] <= bank_wdata;
                end else begin
                    rdata_q <= mem_q[bank_row];
                end
            end
        end

        assign bank_rdata[b] = rdata_q;
    end

    // ---------------------------------------------------------- column side
    always_comb begin
        data_gnt_o = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            data_gnt_o = data_gnt_o | bank_gnt[b];
        end
    end

    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            rvalid_d[c] = data_gnt_o[c] & col_req[c].wen;
            ptr_d[c]    = ptr_q[c];
            // A pointer load beats the post-increment; the access itself
            // has already used the old pointer this cycle.
            if (cfg_ptr_we_i && (cfg_ptr_col_i == COL_W'(c))) begin
                ptr_d[c] = cfg_ptr_i;
            end else if (data_gnt_o[c] && !col_req[c].ind) begin
                ptr_d[c] = ptr_q[c] + DP_WIDTH'(4);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            for (int c = 0; c < N_COL; c++) begin
                ptr_q[c]  <= '0;
                hold_q[c] <= '0;
            end
        end else begin
            rvalid_q <= rvalid_d;
            for (int c = 0; c < N_COL; c++) begin
                ptr_q[c] <= ptr_d[c];
                if (rvalid_q[c]) begin
                    hold_q[c] <= bank_rdata[rbank_q[c]];
                end
            end
        end
    end

    // Which bank a column's read went to; only meaningful while rvalid_q.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < N_COL; c++) begin
            rbank_q[c] <= bank_sel[c];
        end
    end

    // Reset asserted while a read is in flight suppresses its rvalid.
    assign data_rvalid_o = rvalid_q & {N_COL{~rst_i}};

    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            data_rdata_o[c] = data_rvalid_o[c] ? bank_rdata[rbank_q[c]] : hold_q[c];
        end
    end

    assign busy_o = |rvalid_d;

`ifdef CGRA_MEM_PERF_CNT_EN
    logic [DP_WIDTH-1:0] stall_q [N_COL];

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < N_COL; c++) begin
            if (rst_i || perf_clr_i) begin
                stall_q[c] <= '0;
            end else if (req_act[c] && !data_gnt_o[c] && (stall_q[c] != '1)) begin
                stall_q[c] <= stall_q[c] + DP_WIDTH'(1);
            end
        end
    end

    always_comb begin
        for (int c = 0; c < N_COL; c++) begin
            perf_stall_o[c] = stall_q[c];
        end
    end
`endif

endmodule

// File: tb/tb_cgra_col_mem_resp.sv
module tb_cgra_col_mem_resp;
    import cgra_pkg::*;

    logic                           clk = 1'b0;
    logic                           rst = 1'b0;
    logic [N_COL-1:0]               req = '0;
    logic [N_COL-1:0]               wen = '0;
    logic [N_COL-1:0]               ind = '0;
    logic [N_COL-1:0][DP_WIDTH-1:0] add = '0;
    logic [N_COL-1:0][DP_WIDTH-1:0] wdata = '0;
    logic [N_COL-1:0]               gnt;
    logic [N_COL-1:0]               rvalid;
    logic [N_COL-1:0][DP_WIDTH-1:0] rdata;
    logic                           cfg_we = 1'b0;
    logic [COL_W-1:0]               cfg_col = '0;
    logic [DP_WIDTH-1:0]            cfg_ptr = '0;
    logic                           busy;
`ifdef CGRA_MEM_PERF_CNT_EN
    logic                           perf_clr = 1'b0;
    logic [N_COL-1:0][DP_WIDTH-1:0] perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          col;
        logic [31:0] data;
    } exp_t;
    exp_t        sb [$];
    logic [31:0] mdl_mem [1024];
    logic [31:0] mdl_ptr [N_COL];
    bit          pushed_last = 1'b0;
    logic [N_COL-1:0] gseq [8];

    always #5 clk = ~clk;

    cgra_col_mem_resp dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (req),
        .data_wen_i    (wen),
        .data_ind_i    (ind),
        .data_add_i    (add),
        .data_wdata_i  (wdata),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_rdata_o  (rdata),
        .cfg_ptr_we_i  (cfg_we),
        .cfg_ptr_col_i (cfg_col),
        .cfg_ptr_i     (cfg_ptr),
        .busy_o        (busy)
`ifdef CGRA_MEM_PERF_CNT_EN
        ,
        .perf_clr_i    (perf_clr),
        .perf_stall_o  (perf_stall)
`endif
    );

    initial begin
        for (int c = 0; c < N_COL; c++) mdl_ptr[c] = '0;
    end

    // Scoreboard: push expected read data on grant, pop on rvalid.
    always @(negedge clk) begin
        bit          pushed_now;
        logic [31:0] ea;
        exp_t        e;
        pushed_now = 1'b0;
        if (rst) begin
            checks++;
            if (rvalid !== '0 || gnt !== '0) begin
                errors++;
                $display("FAIL reset_outputs: rvalid=%b gnt=%b want 0", rvalid, gnt);
            end
            sb.delete();
            for (int c = 0; c < N_COL; c++) mdl_ptr[c] = '0;
        end else begin
            for (int c = 0; c < N_COL; c++) begin
                if (rvalid[c]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL sb_rvalid col%0d: unexpected rvalid", c);
                    end else begin
                        e = sb.pop_front();
                        if (e.col != c || rdata[c] !== e.data) begin
                            errors++;
                            $display("FAIL sb_rdata col%0d: got %h want %h (col%0d)", c, rdata[c], e.data, e.col);
                        end
                    end
                end
            end
            if (pushed_last) begin
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL sb_latency: %0d reads without rvalid", sb.size());
                    sb.delete();
                end
            end
            for (int c = 0; c < N_COL; c++) begin
                if (gnt[c] && !req[c]) begin
                    errors++;
                    checks++;
                    $display("FAIL gnt_no_req col%0d: gnt=1 want 0", c);
                end
                if (gnt[c] && req[c]) begin
                    ea = ind[c] ? add[c] : mdl_ptr[c];
                    if (!wen[c]) begin
                        mdl_mem[ea[11:2]] = wdata[c];
                    end else begin
                        sb.push_back('{col: c, data: mdl_mem[ea[11:2]]});
                        pushed_now = 1'b1;
                    end
                    if (!ind[c]) mdl_ptr[c] = mdl_ptr[c] + 32'd4;
                end
            end
            if (cfg_we) mdl_ptr[cfg_col] = cfg_ptr;
        end
        pushed_last = pushed_now;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst    = 1'b1;
        req    = '0;
        cfg_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Raise one request and hold it until granted (bounded); waited=-1 on timeout.
    task automatic do_access(input int c, input logic w, input logic i,
                             input logic [31:0] a, input logic [31:0] d, output int waited);
        logic g;
        req[c] = 1'b1; wen[c] = w; ind[c] = i; add[c] = a; wdata[c] = d;
        waited = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            g = gnt[c];
            tick();
            if (g) begin
                waited = k;
                break;
            end
        end
        req[c] = 1'b0;
    endtask

    // Hold a set of read requests, dropping each once granted; grant per cycle to gseq.
    task automatic hold_reqs(input logic [N_COL-1:0] mask);
        logic [N_COL-1:0] cur;
        cur = mask;
        wen = '1;
        ind = '1;
        for (int k = 0; k < 8; k++) gseq[k] = '0;
        req = cur;
        for (int k = 0; k < 8; k++) begin
            if (cur == '0) break;
            @(negedge clk);
            gseq[k] = gnt;
            tick();
            cur = cur & ~gseq[k];
            req = cur;
        end
        req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        wen = '1;
        ind = '1;
        @(negedge clk);
        checks++;
        if (gnt !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: gnt=%b busy=%b want 0 0", gnt, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rdata !== '0 || rvalid !== '0) begin
            errors++;
            $display("FAIL reset_rdata: rdata=%h rvalid=%b want 0", rdata, rvalid);
        end
        tick();
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_basic();
        int w;
        apply_reset();
        do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL basic_wr_gnt: waited %0d want 0", w); end
        @(negedge clk);
        checks++;
        if (rvalid !== '0) begin errors++; $display("FAIL basic_wr_rvalid: %b want 0", rvalid); end
        tick();
        do_access(0, 1'b1, 1'b1, 32'h10, 32'h0, w);
        checks++;
        if (w != 0) begin errors++; $display("FAIL basic_rd_gnt: waited %0d want 0", w); end
        @(negedge clk);
        checks++;
        if (rvalid !== 4'b0001 || rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_rd_data: rvalid=%b rdata=%h want 0001 deadbeef", rvalid, rdata[0]);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rvalid !== '0 || rdata[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL basic_hold: rvalid=%b rdata=%h want 0000 deadbeef", rvalid, rdata[0]);
        end
        tick();
    endtask

    task automatic test_round_robin();
        int w;
        logic [N_COL-1:0] exp_a [3];
        logic [N_COL-1:0] exp_b [4];
        exp_a = '{4'b0001, 4'b0010, 4'b0100};
        exp_b = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
        for (int k = 0; k < 4; k++) do_access(0, 1'b0, 1'b1, 32'(k * 16), 32'hA0 + 32'(k), w);
        apply_reset();
        for (int k = 0; k < 4; k++) add[k] = 32'(k * 16);
        hold_reqs(4'b0111);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gseq[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL rr_round1 step%0d: got %b want %b", k, gseq[k], exp_a[k]);
            end
        end
        hold_reqs(4'b1111);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gseq[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL rr_round2 step%0d: got %b want %b", k, gseq[k], exp_b[k]);
            end
        end
        tick();
    endtask

    task automatic test_banks();
        for (int c = 0; c < N_COL; c++) begin
            add[c]   = 32'h40 + 32'(c * 4);
            wdata[c] = 32'h1234_0000 + 32'(c * 17);
        end
        req = '1; wen = '0; ind = '1;
        @(negedge clk);
        checks++;
        if (gnt !== '1) begin errors++; $display("FAIL banks_wr_gnt: got %b want 1111", gnt); end
        tick();
        wen = '1;
        @(negedge clk);
        checks++;
        if (gnt !== '1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL banks_rd_gnt: gnt=%b busy=%b want 1111 1", gnt, busy);
        end
        tick();
        req = '0;
        @(negedge clk);
        checks++;
        if (rvalid !== '1) begin errors++; $display("FAIL banks_rvalid: got %b want 1111", rvalid); end
        for (int c = 0; c < N_COL; c++) begin
            checks++;
            if (rdata[c] !== 32'h1234_0000 + 32'(c * 17)) begin
                errors++;
                $display("FAIL banks_rdata col%0d: got %h want %h", c, rdata[c], 32'h1234_0000 + 32'(c * 17));
            end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL banks_busy_idle: got %b want 0", busy); end
        tick();
    endtask

    task automatic test_stream_ptr();
        int w;
        cfg_we = 1'b1; cfg_col = 2'd1; cfg_ptr = 32'h100;
        tick();
        cfg_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                cfg_we = 1'b1; cfg_col = 2'd1; cfg_ptr = 32'h100;
            end
            do_access(1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'(k + 1), w);
            cfg_we = 1'b0;
            checks++;
            if (w != 0) begin errors++; $display("FAIL ptr_wr_gnt %0d: waited %0d want 0", k, w); end
        end
        for (int k = 0; k < 3; k++) begin
            do_access(1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, w);
            @(negedge clk);
            checks++;
            if (rvalid[1] !== 1'b1 || rdata[1] !== 32'(k + 1)) begin
                errors++;
                $display("FAIL ptr_rd %0d: rvalid=%b rdata=%h want 1 %h", k, rvalid[1], rdata[1], 32'(k + 1));
            end
            tick();
        end
        do_access(1, 1'b1, 1'b1, 32'h108, 32'h0, w);
        @(negedge clk);
        checks++;
        if (rdata[1] !== 32'd3) begin
            errors++;
            $display("FAIL ptr_collide_old: rdata@108=%h want 3", rdata[1]);
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int w;
        cfg_we = 1'b1; cfg_col = 2'd0; cfg_ptr = 32'h40;
        tick();
        cfg_we = 1'b0;
        do_access(2, 1'b0, 1'b1, 32'h200, 32'h77, w);
        req[0] = 1'b1; wen[0] = 1'b1; ind[0] = 1'b1; add[0] = 32'h200;
        @(negedge clk);
        checks++;
        if (gnt[0] !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_gnt: gnt=%b busy=%b want 1 1", gnt[0], busy);
        end
        tick();
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        checks++;
        if (rvalid !== '0) begin errors++; $display("FAIL midop_rvalid: got %b want 0", rvalid); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid !== '0 || rdata !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: rvalid=%b rdata=%h busy=%b want 0", rvalid, rdata, busy);
        end
        tick();
        do_access(0, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h55, w);
        do_access(0, 1'b1, 1'b1, 32'h0, 32'h0, w);
        @(negedge clk);
        checks++;
        if (rdata[0] !== 32'h55) begin
            errors++;
            $display("FAIL midop_ptr_reset: rdata@0=%h want 55", rdata[0]);
        end
        tick();
    endtask

`ifdef CGRA_MEM_PERF_CNT_EN
    task automatic test_perf();
        int w;
        logic [N_COL-1:0] exp_a [4];
        logic [N_COL-1:0] exp_b [3];
        exp_a = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
        exp_b = '{4'b0100, 4'b1000, 4'b0010};
        apply_reset();
        @(negedge clk);
        checks++;
        if (perf_stall !== '0) begin errors++; $display("FAIL perf_reset: got %h want 0", perf_stall); end
        tick();
        do_access(1, 1'b1, 1'b1, 32'h10, 32'h0, w);
        for (int k = 0; k < 4; k++) add[k] = 32'(k * 16);
        hold_reqs(4'b1111);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (gseq[k] !== exp_a[k]) begin
                errors++;
                $display("FAIL perf_rr_a step%0d: got %b want %b", k, gseq[k], exp_a[k]);
            end
        end
        hold_reqs(4'b1110);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gseq[k] !== exp_b[k]) begin
                errors++;
                $display("FAIL perf_rr_b step%0d: got %b want %b", k, gseq[k], exp_b[k]);
            end
        end
        @(negedge clk);
        checks++;
        if (perf_stall[1] !== 32'd5 || perf_stall[0] !== 32'd2) begin
            errors++;
            $display("FAIL perf_count: col1=%0d col0=%0d want 5 2", perf_stall[1], perf_stall[0]);
        end
        tick();
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (perf_stall !== '0) begin errors++; $display("FAIL perf_clr: got %h want 0", perf_stall); end
        tick();
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_basic();
        test_round_robin();
        test_banks();
        test_stream_ptr();
        test_reset_midop();
`ifdef CGRA_MEM_PERF_CNT_EN
        test_perf();
`endif
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d reads still outstanding", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
